// File: rtl/dma_2d_lite_cfg_master.sv
// rtl/dma_2d_lite_cfg_master.sv - AXI4-Lite master that programs a 2D DMA engine and polls it to completion
`timescale 1ns/1ps
module dma_2d_lite_cfg_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 5,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_POLL_GAP         = 16,
    parameter int C_POLL_TIMEOUT     = 65535
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            i_cmd_valid,
    output logic                            o_cmd_ready,
    input  logic [31:0]                     i_src_addr,
    input  logic [31:0]                     i_dst_addr,
    input  logic [31:0]                     i_img_width,
    input  logic [31:0]                     i_img_height,
    input  logic [31:0]                     i_img_stride,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_error,
    output logic [1:0]                      o_err_code,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_REQ   = 3'd1;
    localparam logic [2:0] S_WR_RESP  = 3'd2;
    localparam logic [2:0] S_POLL_GAP = 3'd3;
    localparam logic [2:0] S_RD_REQ   = 3'd4;
    localparam logic [2:0] S_RD_RESP  = 3'd5;
    localparam logic [2:0] S_FINISH   = 3'd6;

    logic [2:0]  state;
    logic [2:0]  wr_idx;
    logic        aw_done;
    logic        w_done;
    logic [31:0] gap_cnt;
    logic [31:0] poll_cnt;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [31:0] width_q;
    logic [31:0] height_q;
    logic [31:0] stride_q;
    logic [1:0]  err_code;
    logic [7:0]  wr_off;
    logic [31:0] wr_data;
    logic        aw_hs;
    logic        w_hs;
    logic        unused_rdata;

    assign unused_rdata = &{1'b0, M_AXI_RDATA};

    // Register image: parameters first, the start bit at offset 0 last.
    always_comb begin
        wr_off  = 8'h00;
        wr_data = 32'h0000_0001;
        case (wr_idx)
            3'd0:    begin wr_off = 8'h08; wr_data = src_q;    end
            3'd1:    begin wr_off = 8'h0C; wr_data = dst_q;    end
            3'd2:    begin wr_off = 8'h10; wr_data = width_q;  end
            3'd3:    begin wr_off = 8'h14; wr_data = height_q; end
            3'd4:    begin wr_off = 8'h18; wr_data = stride_q; end
            default: begin wr_off = 8'h00; wr_data = 32'h0000_0001; end
        endcase
    end

    assign M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'(wr_off);
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = (state == S_WR_REQ) && !aw_done;
    assign M_AXI_WDATA   = C_M_AXI_DATA_WIDTH'(wr_data);
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = (state == S_WR_REQ) && !w_done;
    assign M_AXI_BREADY  = (state == S_WR_RESP);
    assign M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'(8'h04);
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (state == S_RD_REQ);
    assign M_AXI_RREADY  = (state == S_RD_RESP);

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;

    assign o_cmd_ready = (state == S_IDLE);
    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_FINISH) && (err_code == 2'b00);
    assign o_error     = (state == S_FINISH) && (err_code != 2'b00);
    assign o_err_code  = err_code;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state    <= S_IDLE;
            wr_idx   <= 3'd0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            gap_cnt  <= 32'd0;
            poll_cnt <= 32'd0;
            src_q    <= 32'd0;
            dst_q    <= 32'd0;
            width_q  <= 32'd0;
            height_q <= 32'd0;
            stride_q <= 32'd0;
            err_code <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        src_q    <= i_src_addr;
                        dst_q    <= i_dst_addr;
                        width_q  <= i_img_width;
                        height_q <= i_img_height;
                        stride_q <= i_img_stride;
                        wr_idx   <= 3'd0;
                        poll_cnt <= 32'd0;
                        state    <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    // AW and W may complete in either order or together.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        if (M_AXI_BRESP != 2'b00) begin
                            err_code <= 2'b01;
                            state    <= S_FINISH;
                        end else if (wr_idx == 3'd5) begin
                            gap_cnt <= 32'd0;
                            state   <= S_POLL_GAP;
                        end else begin
                            wr_idx <= wr_idx + 3'd1;
                            state  <= S_WR_REQ;
                        end
                    end
                end
                S_POLL_GAP: begin
                    if (gap_cnt >= 32'(C_POLL_GAP - 1)) state <= S_RD_REQ;
                    else                                  gap_cnt <= gap_cnt + 32'd1;
                end
                S_RD_REQ: begin
                    if (M_AXI_ARREADY) state <= S_RD_RESP;
                end
                S_RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        if (M_AXI_RRESP != 2'b00) begin
                            err_code <= 2'b10;
                            state    <= S_FINISH;
                        end else if (M_AXI_RDATA[0]) begin
                            err_code <= 2'b00;
                            state    <= S_FINISH;
                        end else if (poll_cnt + 32'd1 >= 32'(C_POLL_TIMEOUT)) begin
                            poll_cnt <= poll_cnt + 32'd1;
                            err_code <= 2'b11;
                            state    <= S_FINISH;
                        end else begin
                            poll_cnt <= poll_cnt + 32'd1;
                            gap_cnt  <= 32'd0;
                            state    <= S_POLL_GAP;
                        end
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_2d_lite_cfg_master.sv
// tb/tb_dma_2d_lite_cfg_master.sv - self-checking bench for dma_2d_lite_cfg_master
`timescale 1ns/1ps
module tb_dma_2d_lite_cfg_master;
    localparam int GAP = 3;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] src = 32'd0, dst = 32'd0, wid = 32'd0, hgt = 32'd0, strd = 32'd0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = 32'd0;

    dma_2d_lite_cfg_master #(
        .C_M_AXI_ADDR_WIDTH(5), .C_M_AXI_DATA_WIDTH(32),
        .C_POLL_GAP(GAP), .C_POLL_TIMEOUT(TMO)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_src_addr(src), .i_dst_addr(dst), .i_img_width(wid),
        .i_img_height(hgt), .i_img_stride(strd),
        .o_busy(busy), .o_done(done), .o_error(error), .o_err_code(err_code),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    typedef struct {
        logic [31:0] src, dst, w, h, s;
        int          berr;
        int          done_at;
        int          rerr_at;
        int          skew;
        int          exp_reads;
        logic [1:0]  exp_code;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    int cfg_berr = -1, cfg_done_at = 0, cfg_rerr_at = 0, cfg_skew = 0;
    int done_total = 0, err_total = 0, overlap_total = 0, rdy_viol = 0, cyc = 0;
    int seq_wr = 0, seq_rd = 0, aw_cnt = 0, w_cnt = 0;
    int last_evt = 0, min_space = 1000000, last_reads = 0, last_min = 1000000;
    bit got_aw = 0, got_w = 0, b_fire = 0, r_fire = 0, r_pend = 0, prev_busy = 0;
    logic [4:0]  cap_a;
    logic [31:0] cap_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int aw_delay(int skew, int idx);
        if (skew == 0) return 0;
        case (idx)
            0: return 0;
            1: return 2;
            2: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int w_delay(int skew, int idx);
        if (skew == 0) return 0;
        case (idx)
            0: return 3;
            1: return 0;
            2: return 1;
            default: return 0;
        endcase
    endfunction

    // Monitor: command acceptance feeds the write scoreboard; pulses and protocol rules are tallied.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin
                int n;
                n = (cfg_berr >= 0) ? cfg_berr + 1 : 6;
                for (int i = 0; i < n; i++) begin
                    wr_t e;
                    case (i)
                        0: begin e.a = 5'h08; e.d = src;  end
                        1: begin e.a = 5'h0C; e.d = dst;  end
                        2: begin e.a = 5'h10; e.d = wid;  end
                        3: begin e.a = 5'h14; e.d = hgt;  end
                        4: begin e.a = 5'h18; e.d = strd; end
                        default: begin e.a = 5'h00; e.d = 32'h1; end
                    endcase
                    exp_q.push_back(e);
                end
            end
            if (done)  done_total++;
            if (error) err_total++;
            if ((awvalid || wvalid) && arvalid) overlap_total++;
            if (busy && cmd_ready) rdy_viol++;
        end
    end

    // AXI4-Lite slave: readies/valids change at negedge, handshakes land on the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                got_aw = 0; got_w = 0; b_fire = 0; r_fire = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; seq_wr = 0; seq_rd = 0; prev_busy = 0;
                min_space = 1000000;
                continue;
            end
            if (prev_busy && !busy) begin
                last_reads = seq_rd;
                last_min   = min_space;
            end
            prev_busy = busy;
            if (!busy) begin
                seq_wr = 0; seq_rd = 0; min_space = 1000000;
            end
            if (b_fire) begin
                bvalid = 0; b_fire = 0;
            end else if (bvalid && bready) begin
                b_fire = 1;
                if (seq_wr == 6) last_evt = cyc;
            end
            if (got_aw && got_w) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {27'd0, cap_a}, 64'h1_0000_0000);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", cap_a, e.a);
                    check("write_data", cap_d, e.d);
                end
                got_aw = 0; got_w = 0;
                bresp  = (seq_wr == cfg_berr) ? 2'b10 : 2'b00;
                bvalid = 1;
                seq_wr++;
            end
            if (awready) awready = 0;
            else if (awvalid) begin
                if (aw_cnt >= aw_delay(cfg_skew, seq_wr)) begin
                    awready = 1; cap_a = awaddr; got_aw = 1; aw_cnt = 0;
                end else aw_cnt++;
            end else aw_cnt = 0;
            if (wready) wready = 0;
            else if (wvalid) begin
                if (w_cnt >= w_delay(cfg_skew, seq_wr)) begin
                    wready = 1; cap_d = wdata; got_w = 1; w_cnt = 0;
                end else w_cnt++;
            end else w_cnt = 0;
            if (r_fire) begin
                rvalid = 0; r_fire = 0;
            end else if (rvalid && rready) r_fire = 1;
            if (r_pend) begin
                r_pend = 0;
                rvalid = 1;
                rresp  = (seq_rd == cfg_rerr_at) ? 2'b10 : 2'b00;
                rdata  = (seq_rd == cfg_done_at) ? 32'h0000_0001 : 32'hFFFF_FFFE;
            end
            if (arready) arready = 0;
            else if (arvalid) begin
                arready = 1; r_pend = 1; seq_rd++;
                check("read_addr", araddr, 5'h04);
                if (cyc - last_evt < min_space) min_space = cyc - last_evt;
                last_evt = cyc;
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int d0, e0, ov0;
        @(posedge clk); #1;
        cfg_berr = v.berr; cfg_done_at = v.done_at; cfg_rerr_at = v.rerr_at; cfg_skew = v.skew;
        src = v.src; dst = v.dst; wid = v.w; hgt = v.h; strd = v.s;
        d0 = done_total; e0 = err_total; ov0 = overlap_total;
        cmd_valid = 1;
        @(negedge clk);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
        for (int i = 0; i < 3000 && done_total == d0 && err_total == e0; i++) @(negedge clk);
        if (done_total == d0 && err_total == e0) check({tag, "_completion_timeout"}, 0, 1);
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, done_total - d0, (v.exp_code == 2'b00) ? 1 : 0);
        check({tag, "_error_pulses"}, err_total - e0, (v.exp_code != 2'b00) ? 1 : 0);
        check({tag, "_err_code"}, err_code, v.exp_code);
        check({tag, "_reads"}, last_reads, v.exp_reads);
        check({tag, "_writes_left"}, exp_q.size(), 0);
        check({tag, "_aw_ar_overlap"}, overlap_total - ov0, 0);
        if (v.exp_reads > 0) check({tag, "_read_spacing_ok"}, last_min >= GAP, 1);
        exp_q.delete();
    endtask

    vec_t vt[5];

    initial begin
        int d0, e0, rv0;
        vt[0] = '{32'h1000_0000, 32'h2000_0000, 32'd640, 32'd480, 32'd1024, -1, 3, 0, 0, 3, 2'b00};
        vt[1] = '{32'hA000_0040, 32'hB000_0080, 32'd1920, 32'd1080, 32'd2048, -1, 1, 0, 1, 1, 2'b00};
        vt[2] = '{32'h1111_1110, 32'h2222_2220, 32'd64, 32'd32, 32'd64, 3, 1, 0, 0, 0, 2'b01};
        vt[3] = '{32'h3000_0000, 32'h4000_0000, 32'd8, 32'd8, 32'd16, -1, 0, 0, 0, 4, 2'b11};
        vt[4] = '{32'h5000_0000, 32'h6000_0000, 32'd4, 32'd2, 32'd4, -1, 0, 2, 0, 2, 2'b10};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {awvalid, wvalid, bready, arvalid, rready, busy, done, error, err_code}, 10'd0);
        check("tied_prot_strb", {awprot, arprot, wstrb}, {3'b000, 3'b000, 4'hF});
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("ready_after_reset", cmd_ready, 1);

        for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Reset while a status read is outstanding.
        @(posedge clk); #1;
        cfg_berr = -1; cfg_done_at = 0; cfg_rerr_at = 0; cfg_skew = 0;
        src = 32'hC0DE_0000; dst = 32'hD0DE_0000; wid = 32'd16; hgt = 32'd16; strd = 32'd32;
        cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0;
        d0 = done_total; e0 = err_total;
        for (int i = 0; i < 500 && !rready; i++) @(negedge clk);
        check("reached_rd_resp", rready, 1);
        rst = 1;
        @(negedge clk);
        check("mid_reset_outputs", {awvalid, wvalid, bready, arvalid, rready, busy, done, error, err_code}, 10'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("ready_after_mid_reset", cmd_ready, 1);
        check("no_pulse_on_reset", (done_total - d0) + (err_total - e0), 0);
        exp_q.delete();
        run_vec(vt[0], "post_reset");

        // Command held valid across a whole sequence with changing parameters.
        @(posedge clk); #1;
        cfg_berr = -1; cfg_done_at = 1; cfg_rerr_at = 0; cfg_skew = 0;
        src = 32'h0BAD_0001; dst = 32'h0BAD_0002; wid = 32'd100; hgt = 32'd50; strd = 32'd128;
        d0 = done_total; e0 = err_total; rv0 = rdy_viol;
        cmd_valid = 1;
        for (int i = 0; i < 3000 && done_total == d0; i++) begin
            @(posedge clk); #1;
            if (busy) begin
                src = $urandom; dst = $urandom; wid = $urandom; hgt = $urandom; strd = $urandom;
            end
        end
        check("busy_first_done", done_total - d0, 1);
        @(negedge clk);
        check("ready_after_finish", cmd_ready, 1);
        @(posedge clk); #1;
        check("accepted_after_finish", busy, 1);
        cmd_valid = 0;
        for (int i = 0; i < 3000 && done_total == d0 + 1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("busy_second_done", done_total - d0, 2);
        check("busy_no_error", err_total - e0, 0);
        check("busy_ready_low", rdy_viol - rv0, 0);
        check("busy_writes_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
